// File: rtl/mem_port_arbiter_if.sv
// Bus bundle for mem_port_arbiter: CPU and DMA request ports, RAM port-A drive, status.
// The slave modport is the arbiter; the master modport is the requester/RAM side.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 16
);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_gnt;
    logic              cpu_rvalid;

    logic              dma_req;
    logic              dma_we;
    logic [ADDR_W-1:0] dma_addr;
    logic [DATA_W-1:0] dma_wdata;
    logic              dma_gnt;
    logic              dma_rvalid;

    logic [DATA_W-1:0] rdata;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic              ram_wren;
    logic [DATA_W-1:0] ram_rdata;
    logic              busy;
    logic [1:0]        dbg_state;

    // Handshake: a requester holds req/we/addr/wdata stable until its one-cycle gnt;
    // a read then returns exactly one one-cycle rvalid with the result on rdata.
    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  dma_req, dma_we, dma_addr, dma_wdata,
        input  ram_rdata,
        output cpu_gnt, cpu_rvalid, dma_gnt, dma_rvalid,
        output rdata, ram_addr, ram_wdata, ram_wren, busy, dbg_state
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output dma_req, dma_we, dma_addr, dma_wdata,
        output ram_rdata,
        input  cpu_gnt, cpu_rvalid, dma_gnt, dma_rvalid,
        input  rdata, ram_addr, ram_wdata, ram_wren, busy, dbg_state
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-requester (CPU, DMA) arbiter for block-RAM port A with fixed read latency.
// Round-robin by default; define ARB_CPU_PRIORITY_EN to make the CPU always win ties.
module mem_port_arbiter #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 16,
    parameter int RD_LAT = 2
) (
    input logic              clk,
    input logic              reset,
    mem_port_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, RESP = 2'd3} state_t;

    if ((RD_LAT < 1) || (RD_LAT > 7)) begin : g_bad_rd_lat
        $error("mem_port_arbiter: RD_LAT must be in 1..7");
    end

    localparam logic [2:0] CNT_INIT = 3'(RD_LAT - 1);

    state_t            state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic              owner_q;
    logic              last_winner_q;
    logic              rvalid_q;
    logic [DATA_W-1:0] rdata_q;
    logic [ADDR_W-1:0] ram_addr_q;
    logic [DATA_W-1:0] ram_wdata_q;
    logic              ram_wren_q;

    logic              any_req;
    logic              winner;
    logic              take;
    logic              rd_done;
    logic              win_we;
    logic [ADDR_W-1:0] win_addr;
    logic [DATA_W-1:0] win_wdata;

    // winner: 0 = CPU, 1 = DMA
    always_comb begin
        any_req = bus.cpu_req | bus.dma_req;
        winner  = 1'b0;
        if (bus.cpu_req && bus.dma_req) begin
`ifdef ARB_CPU_PRIORITY_EN
            winner = 1'b0;
`else
            winner = ~last_winner_q;
`endif
        end else if (bus.dma_req) begin
            winner = 1'b1;
        end
        win_we    = winner ? bus.dma_we    : bus.cpu_we;
        win_addr  = winner ? bus.dma_addr  : bus.cpu_addr;
        win_wdata = winner ? bus.dma_wdata : bus.cpu_wdata;
        take      = (state_q == IDLE) && any_req;
        rd_done   = (state_q == WAIT) && (cnt_q == 3'd0);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE:  if (any_req) state_d = ISSUE;
            // ram_wren is only ever high in ISSUE, so it tells a write from a read here
            ISSUE: begin
                if (ram_wren_q) begin
                    state_d = IDLE;
                end else begin
                    state_d = WAIT;
                    cnt_d   = CNT_INIT;
                end
            end
            WAIT: begin
                if (cnt_q == 3'd0) state_d = RESP;
                else               cnt_d   = cnt_q - 3'd1;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            owner_q       <= 1'b0;
            last_winner_q <= 1'b1;
            rvalid_q      <= 1'b0;
            rdata_q       <= '0;
            ram_addr_q    <= '0;
            ram_wdata_q   <= '0;
            ram_wren_q    <= 1'b0;
        end else begin
            if (take) begin
                owner_q       <= winner;
                last_winner_q <= winner;
                ram_addr_q    <= win_addr;
                ram_wdata_q   <= win_wdata;
            end
            ram_wren_q <= take && win_we;
            rvalid_q   <= rd_done;
            if (rd_done) rdata_q <= bus.ram_rdata;
        end
    end

    assign bus.cpu_gnt    = (state_q == ISSUE) && !owner_q;
    assign bus.dma_gnt    = (state_q == ISSUE) &&  owner_q;
    assign bus.cpu_rvalid = rvalid_q && !owner_q;
    assign bus.dma_rvalid = rvalid_q &&  owner_q;
    assign bus.rdata      = rdata_q;
    assign bus.ram_addr   = ram_addr_q;
    assign bus.ram_wdata  = ram_wdata_q;
    assign bus.ram_wren   = ram_wren_q;
    assign bus.busy       = (state_q != IDLE);
    assign bus.dbg_state  = state_q;
endmodule
